matrix_op_sequencer: RTL and testbench

Element-wise sequencer for the matrix coprocessor: once an instruction is accepted, it walks every element of an operand matrix in row-major order. For each element it issues synchronous reads of matrices A and B, drives the combinational matrix ALU, and writes the result into matrix C. It sits below the instruction-level control FSM and turns one arithmetic instruction into a pipelined stream of memory and ALU operations, one element per cycle.

---
 rtl/matrix_pkg.sv | 41 ++++
 rtl/matrix_op_sequencer_if.sv | 41 ++++
 rtl/matrix_addr_gen.sv | 51 +++++
 rtl/matrix_op_sequencer.sv | 103 ++++++++++
 tb/tb_matrix_op_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared constants for the matrix coprocessor sequencer: opcodes, ALU encodings,
// FSM state encoding and default geometry.
package matrix_pkg;

  localparam int MAT_N      = 5;
  localparam int MAT_DATA_W = 8;
  localparam int MAT_ADDR_W = 5;

  localparam logic [3:0] OP_ADD       = 4'b0010;
  localparam logic [3:0] OP_SUB       = 4'b0011;
  localparam logic [3:0] OP_NEG       = 4'b0100;
  localparam logic [3:0] OP_TRANSPOSE = 4'b0101;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_NEG  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic opcode_is_legal(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_NEG, OP_TRANSPOSE};
  endfunction

  function automatic alu_op_t opcode_to_alu(input logic [3:0] op);
    alu_op_t res;
    case (op)
      OP_SUB:       res = ALU_SUB;
      OP_NEG:       res = ALU_NEG;
      OP_TRANSPOSE: res = ALU_PASS;
      default:      res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// Bundle of instruction, memory and ALU signals around the element sequencer.
// slave = sequencer side, master = controller/memory/ALU environment side.
interface matrix_op_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  // start is a level request with no ready: it is sampled only while idle; a legal
  // request raises busy next cycle, an illegal one pulses err; wait for done before the next.
  logic              start;
  logic [3:0]        opcode;
  logic [2:0]        dim;
  logic              busy;
  logic              done;
  logic              err;
  logic              ovf;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data_a;
  logic [DATA_W-1:0] mem_rd_data_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [1:0]        dbg_state;

  modport slave (
    input  start, opcode, dim, mem_rd_data_a, mem_rd_data_b, alu_result, alu_ovf,
    output busy, done, err, ovf, mem_rd_en, mem_rd_addr, alu_op, alu_a, alu_b,
           mem_wr_en, mem_wr_addr, mem_wr_data, dbg_state
  );

  modport master (
    output start, opcode, dim, mem_rd_data_a, mem_rd_data_b, alu_result, alu_ovf,
    input  busy, done, err, ovf, mem_rd_en, mem_rd_addr, alu_op, alu_a, alu_b,
           mem_wr_en, mem_wr_addr, mem_wr_data, dbg_state
  );
endinterface

// File: rtl/matrix_addr_gen.sv
// Row/column walker: row-major read address with stride N, and a write address
// that trails it by one cycle (row/col swapped for transpose).
module matrix_addr_gen #(
  parameter int N      = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic              i_transpose,
  input  logic [2:0]        i_dim,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_last
);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(N);

  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [2:0]        w_dim_m1;
  logic [ADDR_W-1:0] w_tr_addr;

  assign w_dim_m1  = i_dim - 3'd1;
  assign o_last    = (r_row == w_dim_m1) && (r_col == w_dim_m1);
  assign o_rd_addr = ADDR_W'(r_row) * STRIDE + ADDR_W'(r_col);
  assign w_tr_addr = ADDR_W'(r_col) * STRIDE + ADDR_W'(r_row);
  assign o_wr_addr = r_wr_addr;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_row     <= '0;
      r_col     <= '0;
      r_wr_addr <= '0;
    end else if (i_advance) begin
      r_wr_addr <= i_transpose ? w_tr_addr : o_rd_addr;
      // wrap to origin after the last element so the next instruction starts clean
      if (o_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == w_dim_m1) begin
        r_col <= '0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Turns one matrix instruction into a stream of read / ALU / write operations,
// one element per cycle. Optional sticky overflow flag under `OVF_FLAG_EN.
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int N      = MAT_N,
  parameter int DATA_W = MAT_DATA_W,
  parameter int ADDR_W = MAT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  matrix_op_sequencer_if.slave  bus
);
  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [3:0]        r_opcode;
  logic [2:0]        r_dim;
  alu_op_t           r_alu_op;
  logic              r_wr_en;
  logic              r_err;
  logic              w_legal;
  logic              w_accept;
  logic              w_last;
  logic              w_use_b;
  logic              w_transpose;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_legal     = opcode_is_legal(bus.opcode) && (bus.dim >= 3'd2) && (bus.dim <= 3'(N));
  assign w_accept    = (r_state == ST_IDLE) && bus.start && w_legal;
  assign w_transpose = (r_opcode == OP_TRANSPOSE);
  assign w_use_b     = (r_opcode == OP_ADD) || (r_opcode == OP_SUB);

  matrix_addr_gen #(.N(N), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (r_state != ST_RUN),
    .i_advance   (r_state == ST_RUN),
    .i_transpose (w_transpose),
    .i_dim       (r_dim),
    .o_rd_addr   (w_rd_addr),
    .o_wr_addr   (w_wr_addr),
    .o_last      (w_last)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_RUN;
      ST_RUN:   if (w_last) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_opcode <= '0;
      r_dim    <= '0;
      r_alu_op <= ALU_ADD;
      r_wr_en  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // write stage trails each read by one cycle, matching memory latency
      r_wr_en <= (r_state == ST_RUN);
      r_err   <= (r_state == ST_IDLE) && bus.start && !w_legal;
      if (w_accept) begin
        r_opcode <= bus.opcode;
        r_dim    <= bus.dim;
        r_alu_op <= opcode_to_alu(bus.opcode);
      end
    end
  end

`ifdef OVF_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (!reset_n || w_accept) r_ovf <= 1'b0;
    else if (r_wr_en && bus.alu_ovf) r_ovf <= 1'b1;
  end
  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.err         = r_err;
  assign bus.dbg_state   = r_state;
  assign bus.mem_rd_en   = (r_state == ST_RUN);
  assign bus.mem_rd_addr = w_rd_addr;
  assign bus.alu_op      = r_alu_op;
  // operands are held at zero outside write stages so idle/reset outputs stay quiet
  assign bus.alu_a       = r_wr_en ? bus.mem_rd_data_a : {DATA_W{1'b0}};
  assign bus.alu_b       = (r_wr_en && w_use_b) ? bus.mem_rd_data_b : {DATA_W{1'b0}};
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_addr = w_wr_addr;
  assign bus.mem_wr_data = r_wr_en ? bus.alu_result : {DATA_W{1'b0}};

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: memory and ALU models, a table of instructions,
// randomized instructions against an element-list reference model, and reset corners.
module tb_matrix_op_sequencer;
  import matrix_pkg::*;

  localparam int N = 5;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] dim;
    logic       accept;
    logic [2:0] fill;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  matrix_op_sequencer_if #(.DATA_W(8), .ADDR_W(5)) bus ();
  matrix_op_sequencer #(.N(N), .DATA_W(8), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] c_mem [32];
  logic [4:0] got_wr_q [$];
  logic [4:0] got_rd_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       rd_pend = 1'b0;
  logic [4:0] rd_pend_addr = '0;
  logic [7:0] alu_r;
  logic       alu_o;

  // synchronous A/B memories: request seen in cycle k, data visible through cycle k+1
  always @(negedge clk) begin
    rd_pend      = bus.mem_rd_en;
    rd_pend_addr = bus.mem_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      bus.mem_rd_data_a = mem_a[rd_pend_addr];
      bus.mem_rd_data_b = mem_b[rd_pend_addr];
    end
  end

  always_comb begin
    alu_r = 8'h00;
    alu_o = 1'b0;
    case (bus.alu_op)
      2'b00: begin
        alu_r = bus.alu_a + bus.alu_b;
        alu_o = (bus.alu_a[7] == bus.alu_b[7]) && (alu_r[7] != bus.alu_a[7]);
      end
      2'b01: begin
        alu_r = bus.alu_a - bus.alu_b;
        alu_o = (bus.alu_a[7] != bus.alu_b[7]) && (alu_r[7] != bus.alu_a[7]);
      end
      2'b10: begin
        alu_r = 8'h00 - bus.alu_a;
        alu_o = (bus.alu_a == 8'h80);
      end
      default: alu_r = bus.alu_a;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_ovf    = alu_o;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(bus.busy), 0);
    check({tag, "_done"},    32'(bus.done), 0);
    check({tag, "_err"},     32'(bus.err), 0);
    check({tag, "_ovf"},     32'(bus.ovf), 0);
    check({tag, "_rd_en"},   32'(bus.mem_rd_en), 0);
    check({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 0);
    check({tag, "_alu_op"},  32'(bus.alu_op), 0);
    check({tag, "_alu_a"},   32'(bus.alu_a), 0);
    check({tag, "_alu_b"},   32'(bus.alu_b), 0);
    check({tag, "_wr_en"},   32'(bus.mem_wr_en), 0);
    check({tag, "_wr_addr"}, 32'(bus.mem_wr_addr), 0);
    check({tag, "_wr_data"}, 32'(bus.mem_wr_data), 0);
    check({tag, "_state"},   32'(bus.dbg_state), 0);
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < 32; k++) begin
      case (mode)
        0: begin mem_a[k] = 8'(k); mem_b[k] = 8'(2 * k); end
        1: begin mem_a[k] = 8'h00; mem_b[k] = 8'h01; end
        2: begin mem_a[k] = 8'((k / N) * 10 + k % N); mem_b[k] = 8'($urandom); end
        4: begin mem_a[k] = 8'(k); mem_b[k] = 8'h00; end
        default: begin mem_a[k] = 8'($urandom); mem_b[k] = 8'($urandom); end
      endcase
    end
    if (mode == 1) begin
      mem_a[0] = 8'd10; mem_a[1] = 8'd20; mem_a[5] = 8'd30; mem_a[6] = 8'd40;
    end
    if (mode == 4) begin
      mem_a[0] = 8'h7F; mem_b[0] = 8'h01;
    end
  endtask

  task automatic run_and_check(input logic [3:0] op, input logic [2:0] d, input logic hold);
    logic [4:0] exp_rd [$];
    logic [4:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic [7:0] exp_c [32];
    logic [1:0] exp_alu;
    logic       exp_ovf;
    int m, ra, wa, sa, sb, v, done_at, bad_c;
    int bad_busy, bad_rd, bad_wr, bad_done, bad_err;
    m = int'(d) * int'(d);
    exp_ovf = 1'b0;
    done_at = -1;
    bad_busy = 0; bad_rd = 0; bad_wr = 0; bad_done = 0; bad_err = 0; bad_c = 0;
    case (op)
      OP_SUB:  exp_alu = 2'b01;
      OP_NEG:  exp_alu = 2'b10;
      OP_TRANSPOSE: exp_alu = 2'b11;
      default: exp_alu = 2'b00;
    endcase
    for (int a = 0; a < 32; a++) begin
      exp_c[a] = 8'hA5;
      c_mem[a] = 8'hA5;
    end
    got_wr_q.delete();
    got_rd_q.delete();
    // reference: list of elements in row-major order with their result and destination
    for (int r = 0; r < int'(d); r++) begin
      for (int c = 0; c < int'(d); c++) begin
        ra = r * N + c;
        wa = (op == OP_TRANSPOSE) ? c * N + r : ra;
        sa = int'($signed(mem_a[ra]));
        sb = int'($signed(mem_b[ra]));
        case (op)
          OP_ADD:  v = sa + sb;
          OP_SUB:  v = sa - sb;
          OP_NEG:  v = -sa;
          default: v = sa;
        endcase
        if (v > 127 || v < -128) exp_ovf = 1'b1;
        exp_rd.push_back(5'(ra));
        exp_wa.push_back(5'(wa));
        exp_wd.push_back(8'(v));
        exp_a.push_back(mem_a[ra]);
        exp_b.push_back((op == OP_ADD || op == OP_SUB) ? mem_b[ra] : 8'h00);
        exp_c[wa] = 8'(v);
      end
    end
`ifndef OVF_FLAG_EN
    exp_ovf = 1'b0;
`endif
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = op; bus.dim = d;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int k = 1; k <= m + 3; k++) begin
      @(negedge clk);
      if (bus.busy !== (k <= m + 1)) bad_busy++;
      if (bus.mem_rd_en !== (k <= m)) bad_rd++;
      if (bus.mem_wr_en !== (k >= 2 && k <= m + 1)) bad_wr++;
      if (bus.done !== (k == m + 2)) bad_done++;
      if (bus.done === 1'b1 && done_at < 0) done_at = k;
      if (bus.err !== 1'b0) bad_err++;
      if (bus.mem_rd_en === 1'b1) begin
        got_rd_q.push_back(bus.mem_rd_addr);
        if (exp_rd.size() > 0) check("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_rd.pop_front()));
        else bad_rd++;
      end
      if (bus.mem_wr_en === 1'b1) begin
        got_wr_q.push_back(bus.mem_wr_addr);
        c_mem[bus.mem_wr_addr] = bus.mem_wr_data;
        if (exp_wa.size() > 0) begin
          check("wr_addr", 32'(bus.mem_wr_addr), 32'(exp_wa.pop_front()));
          check("wr_data", 32'(bus.mem_wr_data), 32'(exp_wd.pop_front()));
          check("alu_a",   32'(bus.alu_a), 32'(exp_a.pop_front()));
          check("alu_b",   32'(bus.alu_b), 32'(exp_b.pop_front()));
        end else bad_wr++;
      end
      if (k == 1) check("ovf_cleared", 32'(bus.ovf), 0);
      if (k == 2) check("alu_op", 32'(bus.alu_op), 32'(exp_alu));
      if (k >= m + 2) check("ovf_final", 32'(bus.ovf), 32'(exp_ovf));
      if (hold && k == m + 2) bus.start = 1'b0;
    end
    for (int a = 0; a < 32; a++) if (c_mem[a] !== exp_c[a]) bad_c++;
    check("done_cycle",  32'(done_at), 32'(m + 2));
    check("busy_window", 32'(bad_busy), 0);
    check("rd_window",   32'(bad_rd), 0);
    check("wr_window",   32'(bad_wr), 0);
    check("done_window", 32'(bad_done), 0);
    check("no_err",      32'(bad_err), 0);
    check("rd_left",     32'(exp_rd.size()), 0);
    check("wr_left",     32'(exp_wa.size()), 0);
    check("c_contents",  32'(bad_c), 0);
  endtask

  task automatic reject_check(input logic [3:0] op, input logic [2:0] d);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = op; bus.dim = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("rej_err",   32'(bus.err), 1);
    check("rej_busy",  32'(bus.busy), 0);
    check("rej_rd_en", 32'(bus.mem_rd_en), 0);
    check("rej_wr_en", 32'(bus.mem_wr_en), 0);
    @(negedge clk);
    check("rej_err_pulse", 32'(bus.err), 0);
    check("rej_rd_en2",    32'(bus.mem_rd_en), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [13];
    logic [4:0]  tr_rd [9];
    logic [4:0]  tr_wr [9];
    bus.start = 1'b0; bus.opcode = 4'h0; bus.dim = 3'd0;
    bus.mem_rd_data_a = 8'h00; bus.mem_rd_data_b = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    vecs[0]  = '{OP_ADD,       3'd5, 1'b1, 3'd0};
    vecs[1]  = '{OP_SUB,       3'd2, 1'b1, 3'd1};
    vecs[2]  = '{OP_NEG,       3'd2, 1'b1, 3'd1};
    vecs[3]  = '{OP_TRANSPOSE, 3'd3, 1'b1, 3'd2};
    vecs[4]  = '{4'b1111,      3'd3, 1'b0, 3'd0};
    vecs[5]  = '{OP_ADD,       3'd1, 1'b0, 3'd0};
    vecs[6]  = '{OP_ADD,       3'd6, 1'b0, 3'd0};
    vecs[7]  = '{4'b0000,      3'd2, 1'b0, 3'd0};
    vecs[8]  = '{4'b0110,      3'd4, 1'b0, 3'd0};
    vecs[9]  = '{OP_SUB,       3'd0, 1'b0, 3'd0};
    vecs[10] = '{OP_ADD,       3'd2, 1'b1, 3'd4};
    vecs[11] = '{OP_NEG,       3'd4, 1'b1, 3'd3};
    vecs[12] = '{OP_TRANSPOSE, 3'd7, 1'b0, 3'd0};
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].accept) begin
        fill(int'(vecs[i].fill));
        run_and_check(vecs[i].op, vecs[i].dim, 1'b0);
      end else begin
        reject_check(vecs[i].op, vecs[i].dim);
      end
    end

    // transpose address order against the literal lists
    tr_rd = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12};
    tr_wr = '{5'd0, 5'd5, 5'd10, 5'd1, 5'd6, 5'd11, 5'd2, 5'd7, 5'd12};
    fill(2);
    run_and_check(OP_TRANSPOSE, 3'd3, 1'b0);
    check("tr_rd_count", 32'(got_rd_q.size()), 9);
    check("tr_wr_count", 32'(got_wr_q.size()), 9);
    for (int j = 0; j < 9; j++) begin
      if (j < got_rd_q.size()) check("tr_rd_seq", 32'(got_rd_q[j]), 32'(tr_rd[j]));
      if (j < got_wr_q.size()) check("tr_wr_seq", 32'(got_wr_q[j]), 32'(tr_wr[j]));
    end

    // start held high through busy and DONE must be ignored
    fill(3);
    run_and_check(OP_ADD, 3'd4, 1'b1);

    // reset in the middle of a 5x5 add, then a clean instruction
    fill(0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = OP_ADD; bus.dim = 3'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("pre_reset_wr_en", 32'(bus.mem_wr_en), 1);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
    fill(3);
    run_and_check(OP_SUB, 3'd3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      logic [3:0] rop;
      case ($urandom_range(0, 3))
        0:       rop = OP_ADD;
        1:       rop = OP_SUB;
        2:       rop = OP_NEG;
        default: rop = OP_TRANSPOSE;
      endcase
      fill(3);
      run_and_check(rop, 3'($urandom_range(2, 5)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
